// File: rtl/inst_rom_ld_if.sv
// Fetch and boot-load signal bundle for inst_rom_ld.
// ld_csum_o exists only when INST_ROM_LD_CSUM_EN is defined.
interface inst_rom_ld_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              ce_i;
    logic [31:0]       addr_i;
    logic [31:0]       inst_o;
    logic              ld_start_i;
    logic              ld_valid_i;
    logic [7:0]        ld_byte_i;
    logic              ld_last_i;
    logic              ld_ready_o;
    logic              ld_busy_o;
    logic              ld_done_o;
    logic              ld_ovf_o;
    logic [ADDR_W:0]   ld_words_o;
`ifdef INST_ROM_LD_CSUM_EN
    logic [15:0]       ld_csum_o;

    modport slave (
        input  ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        output inst_o, ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o, ld_words_o, ld_csum_o
    );
    modport master (
        output ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        input  inst_o, ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o, ld_words_o, ld_csum_o
    );
`else
    modport slave (
        input  ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        output inst_o, ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o, ld_words_o
    );
    modport master (
        output ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        input  inst_o, ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o, ld_words_o
    );
`endif
endinterface

// File: rtl/inst_rom_ld.sv
// Instruction ROM: zero-latency fetch port plus byte-serial big-endian boot loader.
// Define INST_ROM_LD_CSUM_EN to add the ld_csum_o running byte checksum.
module inst_rom_ld #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    inst_rom_ld_if.slave bus
);
    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

    state_e          r_state;
    logic [1:0]      r_cnt;
    logic [31:0]     r_asm;
    logic [ADDR_W:0] r_words;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_ovf;
    logic [31:0]     r_mem [DEPTH];
`ifdef INST_ROM_LD_CSUM_EN
    logic [15:0]     r_csum;
`endif

    logic              w_accept;
    logic              w_full;
    logic              w_word_end;
    logic              w_flush;
    logic              w_we;
    logic [31:0]       w_asm_next;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_idx;
    logic              w_fetch_ok;

    // Fetch is only served while no load is rewriting the array.
    assign w_idx      = bus.addr_i[ADDR_W+1:2];
    assign w_fetch_ok = bus.ce_i && (r_state == StIdle || r_state == StDone) &&
                        (bus.addr_i[31:ADDR_W+2] == '0);
    assign bus.inst_o = w_fetch_ok ? r_mem[w_idx] : NOP_WORD;

    // A restart pulse wins over a byte presented in the same cycle.
    assign w_accept   = r_ready && bus.ld_valid_i && !bus.ld_start_i;
    assign w_full     = (r_words == DEPTH_CNT);
    assign w_word_end = w_accept && (r_cnt == 2'd3);
    assign w_flush    = (r_state == StFlush);
    assign w_we       = (w_word_end || w_flush) && !w_full;
    assign w_wdata    = w_flush ? r_asm : w_asm_next;

    always_comb begin
        w_asm_next = r_asm;
        unique case (r_cnt)
            2'd0: w_asm_next[31:24] = bus.ld_byte_i;
            2'd1: w_asm_next[23:16] = bus.ld_byte_i;
            2'd2: w_asm_next[15:8]  = bus.ld_byte_i;
            2'd3: w_asm_next[7:0]   = bus.ld_byte_i;
            default: w_asm_next = r_asm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_words[ADDR_W-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_words <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef INST_ROM_LD_CSUM_EN
            r_csum  <= '0;
`endif
        end else if (bus.ld_start_i && r_state != StFlush) begin
            r_state <= StLoad;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_words <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef INST_ROM_LD_CSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            case (r_state)
                StLoad: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 2'd1;
                        r_asm <= (r_cnt == 2'd3) ? '0 : w_asm_next;
`ifdef INST_ROM_LD_CSUM_EN
                        r_csum <= r_csum + {8'h00, bus.ld_byte_i};
`endif
                        if (r_cnt == 2'd3) begin
                            if (w_full) r_ovf <= 1'b1;
                            else        r_words <= r_words + ONE_CNT;
                        end
                        if (bus.ld_last_i) begin
                            r_ready <= 1'b0;
                            if (r_cnt == 2'd3) begin
                                r_state <= StDone;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= StFlush;
                            end
                        end
                    end
                end
                StFlush: begin
                    if (w_full) r_ovf <= 1'b1;
                    else        r_words <= r_words + ONE_CNT;
                    r_asm   <= '0;
                    r_cnt   <= '0;
                    r_state <= StDone;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ld_ready_o = r_ready;
    assign bus.ld_busy_o  = r_busy;
    assign bus.ld_done_o  = r_done;
    assign bus.ld_ovf_o   = r_ovf;
    assign bus.ld_words_o = r_words;
`ifdef INST_ROM_LD_CSUM_EN
    assign bus.ld_csum_o  = r_csum;
`endif
endmodule

// File: tb/tb_inst_rom_ld.sv
// Randomized self-checking bench for inst_rom_ld; expected memory image is built
// from each byte stream by a whole-image packing model.
module tb_inst_rom_ld;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef logic [7:0] bq_t[$];

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] exp_mem   [DEPTH];
    bit          exp_known [DEPTH];
    int          exp_words;
    bit          exp_ovf;
    logic [15:0] exp_csum;

    inst_rom_ld_if #(.ADDR_W(ADDR_W)) bus ();

    inst_rom_ld #(
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Whole-image model: pack bytes big-endian, zero-pad a trailing partial word.
    function automatic void model_load(input bq_t q, input bit complete);
        int n = q.size();
        int nw = complete ? (n + 3) / 4 : n / 4;
        for (int w = 0; w < nw && w < int'(DEPTH); w++) begin
            logic [31:0] word = '0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < n) word |= {24'h0, q[4 * w + b]} << (24 - 8 * b);
            exp_mem[w]   = word;
            exp_known[w] = 1'b1;
        end
        exp_words = (nw > int'(DEPTH)) ? int'(DEPTH) : nw;
        exp_ovf   = (nw > int'(DEPTH));
        exp_csum  = '0;
        foreach (q[i]) exp_csum += {8'h00, q[i]};
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.ld_start_i = 1'b1;
        @(negedge clk);
        bus.ld_start_i = 1'b0;
    endtask

    task automatic send(input bq_t q, input bit mark_last);
        for (int i = 0; i < q.size(); i++) begin
            bus.ld_valid_i = 1'b0;
            bus.ld_byte_i  = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.ld_valid_i = 1'b1;
            bus.ld_byte_i  = q[i];
            bus.ld_last_i  = mark_last && (i == q.size() - 1);
            check_eq("ready_in_load", {31'h0, bus.ld_ready_o}, 32'h1);
            @(negedge clk);
        end
        bus.ld_valid_i = 1'b0;
        bus.ld_last_i  = 1'b0;
        if (mark_last && (q.size() % 4 != 0)) begin
            check_eq("flush_ready", {31'h0, bus.ld_ready_o}, 32'h0);
            check_eq("flush_busy", {31'h0, bus.ld_busy_o}, 32'h1);
        end
    endtask

    task automatic check_fetch_all();
        for (int w = 0; w < int'(DEPTH); w++) begin
            if (exp_known[w]) begin
                bus.ce_i   = 1'b1;
                bus.addr_i = 32'(4 * w + $urandom_range(0, 3));
                #1 check_eq($sformatf("fetch_w%0d", w), bus.inst_o, exp_mem[w]);
            end
            bus.addr_i = (32'h1 << (ADDR_W + 2 + $urandom_range(0, 29 - ADDR_W))) | 32'(4 * w);
            #1 check_eq("fetch_oob", bus.inst_o, NOP);
            bus.ce_i   = 1'b0;
            bus.addr_i = 32'(4 * w);
            #1 check_eq("fetch_ce0", bus.inst_o, NOP);
        end
    endtask

    task automatic finish_load(input bq_t q);
        model_load(q, 1'b1);
        for (int i = 0; i < 8 && !bus.ld_done_o; i++) @(negedge clk);
        check_eq("done", {31'h0, bus.ld_done_o}, 32'h1);
        check_eq("busy_done", {31'h0, bus.ld_busy_o}, 32'h0);
        check_eq("ready_done", {31'h0, bus.ld_ready_o}, 32'h0);
        check_eq("words", 32'(bus.ld_words_o), 32'(exp_words));
        check_eq("ovf", {31'h0, bus.ld_ovf_o}, {31'h0, exp_ovf});
`ifdef INST_ROM_LD_CSUM_EN
        check_eq("csum", {16'h0, bus.ld_csum_o}, {16'h0, exp_csum});
`endif
        check_fetch_all();
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t q;
        n_vec = 0;
        n_err = 0;
        foreach (exp_known[i]) exp_known[i] = 1'b0;
        rst            = 1'b0;
        bus.ce_i       = 1'b0;
        bus.addr_i     = '0;
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b0;
        bus.ld_byte_i  = '0;
        bus.ld_last_i  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_inst", bus.inst_o, NOP);
        check_eq("rst_ready", {31'h0, bus.ld_ready_o}, 32'h0);
        check_eq("rst_done", {31'h0, bus.ld_done_o}, 32'h0);
        check_eq("rst_busy", {31'h0, bus.ld_busy_o}, 32'h0);
        check_eq("rst_ovf", {31'h0, bus.ld_ovf_o}, 32'h0);
        check_eq("rst_words", 32'(bus.ld_words_o), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", {31'h0, bus.ld_ready_o}, 32'h0);

        // Two full words 01..08.
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        pulse_start();
        send(q, 1'b1);
        finish_load(q);
        bus.ce_i = 1'b1;
        bus.addr_i = 32'h4;
        #1 check_eq("fetch_addr4", bus.inst_o, 32'h0506_0708);
        bus.addr_i = 32'h0;
        #1 check_eq("fetch_addr0", bus.inst_o, 32'h0102_0304);

        // Fetch is blocked while loading; then a partial word is flushed.
        pulse_start();
        bus.ce_i = 1'b1;
        bus.addr_i = 32'h0;
        #1 check_eq("fetch_in_load", bus.inst_o, NOP);
        check_eq("busy_in_load", {31'h0, bus.ld_busy_o}, 32'h1);
        bus.ce_i = 1'b0;
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send(q, 1'b1);
        finish_load(q);
        bus.ce_i = 1'b1;
        bus.addr_i = 32'h4;
        #1 check_eq("flush_word", bus.inst_o, 32'hEE00_0000);
        bus.ce_i = 1'b0;

        // Overflow: five words into a four-word array.
        q = rand_bytes(20);
        pulse_start();
        send(q, 1'b1);
        finish_load(q);
        check_eq("ovf_set", {31'h0, bus.ld_ovf_o}, 32'h1);
        pulse_start();
        check_eq("ovf_cleared", {31'h0, bus.ld_ovf_o}, 32'h0);
        check_eq("words_cleared", 32'(bus.ld_words_o), 32'h0);
        check_eq("done_cleared", {31'h0, bus.ld_done_o}, 32'h0);

        // Restart mid-word: the byte coincident with start is dropped.
        q = rand_bytes(6);
        send(q, 1'b0);
        model_load(q, 1'b0);
        bus.ld_valid_i = 1'b1;
        bus.ld_byte_i  = 8'($urandom);
        bus.ld_start_i = 1'b1;
        @(negedge clk);
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b0;
        check_eq("restart_words", 32'(bus.ld_words_o), 32'h0);
        q = rand_bytes($urandom_range(3, 7));
        send(q, 1'b1);
        finish_load(q);

        repeat (6) begin
            q = rand_bytes($urandom_range(1, 20));
            pulse_start();
            send(q, 1'b1);
            finish_load(q);
        end

        // Asynchronous reset mid-load keeps already written words.
        pulse_start();
        q = rand_bytes(5);
        send(q, 1'b0);
        model_load(q, 1'b0);
        rst = 1'b0;
        #1 check_eq("arst_busy", {31'h0, bus.ld_busy_o}, 32'h0);
        check_eq("arst_ready", {31'h0, bus.ld_ready_o}, 32'h0);
        check_eq("arst_words", 32'(bus.ld_words_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_fetch_all();

        // A valid byte in IDLE is ignored.
        bus.ld_valid_i = 1'b1;
        bus.ld_byte_i  = 8'h55;
        @(negedge clk);
        bus.ld_valid_i = 1'b0;
        check_eq("idle_byte_ready", {31'h0, bus.ld_ready_o}, 32'h0);
        check_eq("idle_byte_words", 32'(bus.ld_words_o), 32'h0);
`ifdef INST_ROM_LD_CSUM_EN
        check_eq("idle_byte_csum", {16'h0, bus.ld_csum_o}, 32'h0);
`endif

        q = '{8'hFF, 8'hFF, 8'h01, 8'h02};
        pulse_start();
        send(q, 1'b1);
        finish_load(q);
`ifdef INST_ROM_LD_CSUM_EN
        check_eq("csum_known", {16'h0, bus.ld_csum_o}, 32'h0000_0201);
`endif
        bus.ce_i = 1'b1;
        bus.addr_i = 32'h0;
        #1 check_eq("fetch_ffff", bus.inst_o, 32'hFFFF_0102);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
